// File: rtl/fpnew_opgroup_rob_if.sv
// Issue / completion / retirement bundle for the operation-group reorder buffer.
// slave = buffer side, master = dispatch/slices/consumer side.
interface fpnew_opgroup_rob_if #(
  parameter int unsigned Width       = 32,
  parameter int unsigned NumChannels = 5,
  parameter int unsigned Depth       = 8,
  parameter int unsigned TagWidth    = 4
);
  localparam int unsigned IdW = $clog2(Depth);
  localparam int unsigned ChW = (NumChannels > 1) ? $clog2(NumChannels) : 1;

  logic                                  flush_i;
  logic                                  issue_valid_i;
  logic                                  issue_ready_o;
  logic [ChW-1:0]                        issue_chan_i;
  logic [TagWidth-1:0]                   issue_tag_i;
  logic [IdW-1:0]                        issue_id_o;
  logic [NumChannels-1:0]                cmp_valid_i;
  logic [NumChannels-1:0][IdW-1:0]       cmp_id_i;
  logic [NumChannels-1:0][Width-1:0]     cmp_result_i;
  logic [NumChannels-1:0][4:0]           cmp_status_i;
  logic [NumChannels-1:0]                cmp_ext_i;
  logic                                  out_valid_o;
  logic                                  out_ready_i;
  logic [Width-1:0]                      result_o;
  logic [4:0]                            status_o;
  logic                                  ext_bit_o;
  logic [TagWidth-1:0]                   tag_o;
  logic [ChW-1:0]                        chan_o;
  logic [IdW:0]                          count_o;
  logic                                  busy_o;
  logic                                  err_o;

  modport slave (
    input  flush_i, issue_valid_i, issue_chan_i, issue_tag_i,
           cmp_valid_i, cmp_id_i, cmp_result_i, cmp_status_i, cmp_ext_i, out_ready_i,
    output issue_ready_o, issue_id_o, out_valid_o, result_o, status_o, ext_bit_o,
           tag_o, chan_o, count_o, busy_o, err_o
  );

  modport master (
    output flush_i, issue_valid_i, issue_chan_i, issue_tag_i,
           cmp_valid_i, cmp_id_i, cmp_result_i, cmp_status_i, cmp_ext_i, out_ready_i,
    input  issue_ready_o, issue_id_o, out_valid_o, result_o, status_o, ext_bit_o,
           tag_o, chan_o, count_o, busy_o, err_o
  );
endinterface

// File: rtl/fpnew_opgroup_rob.sv
// In-order completion buffer: slices complete by entry ID in any order,
// results retire on one port strictly in issue order.
module fpnew_opgroup_rob #(
  parameter int unsigned Width       = 32,
  parameter int unsigned NumChannels = 5,
  parameter int unsigned Depth       = 8,
  parameter int unsigned TagWidth    = 4,
  localparam int unsigned IdW = $clog2(Depth),
  localparam int unsigned ChW = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input logic                  clk_i,
  input logic                  rst_i,
  fpnew_opgroup_rob_if.slave   bus
);

  logic [Depth-1:0]                alloc_q, done_q;
  logic [Depth-1:0][ChW-1:0]       chan_q;
  logic [Depth-1:0][TagWidth-1:0]  tag_q;
  logic [Depth-1:0][Width-1:0]     result_q;
  logic [Depth-1:0][4:0]           status_q;
  logic [Depth-1:0]                ext_q;
  logic [IdW-1:0]                  rd_ptr_q, wr_ptr_q;
  logic [IdW:0]                    count_q;
  logic                            err_q;

  logic full, fire, retire;

  assign full              = (count_q == (IdW+1)'(Depth));
  assign bus.issue_ready_o = !full & !bus.flush_i & !rst_i;
  assign fire              = bus.issue_valid_i & bus.issue_ready_o;
  assign bus.issue_id_o    = wr_ptr_q;
  assign bus.out_valid_o   = done_q[rd_ptr_q] & !bus.flush_i & !rst_i;
  assign retire            = bus.out_valid_o & bus.out_ready_i;

  // Per-channel acceptance; an entry issued this very cycle counts as pending.
  logic [NumChannels-1:0] cmp_ok, cmp_err;

  for (genvar c = 0; c < NumChannels; c++) begin : g_ch
    logic [IdW-1:0] id;
    logic           fresh, pend, chan_ok, dup;

    assign id      = bus.cmp_id_i[c];
    assign fresh   = fire & (wr_ptr_q == id);
    assign pend    = (alloc_q[id] | fresh) & ~done_q[id];
    assign chan_ok = fresh ? (bus.issue_chan_i == ChW'(c)) : (chan_q[id] == ChW'(c));

    // A lower-indexed channel naming the same ID wins.
    always_comb begin
      dup = 1'b0;
      for (int k = 0; k < c; k++)
        if (bus.cmp_valid_i[k] && (bus.cmp_id_i[k] == id)) dup = 1'b1;
    end

    assign cmp_ok[c]  = bus.cmp_valid_i[c] & pend & chan_ok & ~dup;
    assign cmp_err[c] = bus.cmp_valid_i[c] & ~(pend & chan_ok & ~dup);
  end

  // At most one accepted completion can target a given entry.
  logic [Depth-1:0]             done_set;
  logic [Depth-1:0][Width-1:0]  res_n;
  logic [Depth-1:0][4:0]        st_n;
  logic [Depth-1:0]             ext_n;

  always_comb begin
    done_set = '0;
    res_n    = '0;
    st_n     = '0;
    ext_n    = '0;
    for (int i = 0; i < Depth; i++)
      for (int c = 0; c < NumChannels; c++)
        if (cmp_ok[c] && (bus.cmp_id_i[c] == IdW'(i))) begin
          done_set[i] = 1'b1;
          res_n[i]    = bus.cmp_result_i[c];
          st_n[i]     = bus.cmp_status_i[c];
          ext_n[i]    = bus.cmp_ext_i[c];
        end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || bus.flush_i) begin
      alloc_q  <= '0;
      done_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (fire) begin
        alloc_q[wr_ptr_q] <= 1'b1;
        chan_q[wr_ptr_q]  <= bus.issue_chan_i;
        tag_q[wr_ptr_q]   <= bus.issue_tag_i;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      if (retire) begin
        alloc_q[rd_ptr_q] <= 1'b0;
        done_q[rd_ptr_q]  <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + 1'b1;
      end
      for (int i = 0; i < Depth; i++)
        if (done_set[i]) begin
          done_q[i]   <= 1'b1;
          result_q[i] <= res_n[i];
          status_q[i] <= st_n[i];
          ext_q[i]    <= ext_n[i];
        end
      if (fire && !retire)      count_q <= count_q + 1'b1;
      else if (!fire && retire) count_q <= count_q - 1'b1;
      if (|cmp_err) err_q <= 1'b1;
    end
  end

  assign bus.result_o  = bus.out_valid_o ? result_q[rd_ptr_q] : '0;
  assign bus.status_o  = bus.out_valid_o ? status_q[rd_ptr_q] : '0;
  assign bus.ext_bit_o = bus.out_valid_o & ext_q[rd_ptr_q];
  assign bus.tag_o     = bus.out_valid_o ? tag_q[rd_ptr_q]    : '0;
  assign bus.chan_o    = bus.out_valid_o ? chan_q[rd_ptr_q]   : '0;
  assign bus.count_o   = count_q;
  assign bus.busy_o    = (count_q != '0);
  assign bus.err_o     = err_q;

endmodule

// File: tb/tb_fpnew_opgroup_rob.sv
// Directed bench for fpnew_opgroup_rob: expected retirements are queued at issue
// and popped/compared whenever the buffer retires an entry.
module tb_fpnew_opgroup_rob;
  localparam int unsigned Width = 32, NumChannels = 5, Depth = 8, TagWidth = 4;
  localparam int unsigned IdW = 3, ChW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpnew_opgroup_rob_if #(.Width(Width), .NumChannels(NumChannels), .Depth(Depth),
                         .TagWidth(TagWidth)) bus ();

  fpnew_opgroup_rob #(.Width(Width), .NumChannels(NumChannels), .Depth(Depth),
                      .TagWidth(TagWidth)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  typedef struct {
    logic [TagWidth-1:0] tag;
    logic [ChW-1:0]      chan;
    logic [Width-1:0]    res;
    logic [4:0]          st;
    logic                ext;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [Width-1:0] res_of(input logic [TagWidth-1:0] t);
    return 32'hC0DE_0000 | (32'(t) * 32'h0000_0101);
  endfunction
  function automatic logic [4:0] st_of(input logic [TagWidth-1:0] t);
    return {1'b1, t} ^ 5'h0A;
  endfunction

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", nm, obs, exp);
    end
  endtask

  task automatic iss(input int ch, input int tg, input bit push);
    exp_t e;
    bus.issue_valid_i = 1'b1;
    bus.issue_chan_i  = ChW'(ch);
    bus.issue_tag_i   = TagWidth'(tg);
    if (push) begin
      e.tag  = TagWidth'(tg);
      e.chan = ChW'(ch);
      e.res  = res_of(e.tag);
      e.st   = st_of(e.tag);
      e.ext  = ^e.tag;
      exp_q.push_back(e);
    end
  endtask

  task automatic cmp(input int ch, input int id, input logic [Width-1:0] r,
                     input logic [4:0] s, input logic x);
    bus.cmp_valid_i[ch]  = 1'b1;
    bus.cmp_id_i[ch]     = IdW'(id);
    bus.cmp_result_i[ch] = r;
    bus.cmp_status_i[ch] = s;
    bus.cmp_ext_i[ch]    = x;
  endtask

  task automatic cmp_ok(input int ch, input int id, input int tg);
    logic [TagWidth-1:0] t;
    t = TagWidth'(tg);
    cmp(ch, id, res_of(t), st_of(t), ^t);
  endtask

  task automatic mon();
    exp_t e;
    if (bus.out_valid_o && bus.out_ready_i) begin
      chk("ret_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("ret_tag",    64'(bus.tag_o),     64'(e.tag));
        chk("ret_chan",   64'(bus.chan_o),    64'(e.chan));
        chk("ret_result", 64'(bus.result_o),  64'(e.res));
        chk("ret_status", 64'(bus.status_o),  64'(e.st));
        chk("ret_ext",    64'(bus.ext_bit_o), 64'(e.ext));
      end
    end
  endtask

  // Close the current cycle: score any retirement, step past the edge, drop pulses.
  task automatic fin();
    mon();
    @(posedge clk); #1;
    bus.issue_valid_i = 1'b0;
    bus.cmp_valid_i   = '0;
    bus.flush_i       = 1'b0;
  endtask

  task automatic cyc();
    @(negedge clk);
    fin();
  endtask

  task automatic do_flush();
    bus.flush_i = 1'b1;
    @(negedge clk);
    chk("flush_oval", 64'(bus.out_valid_o), 64'd0);
    chk("flush_rdy",  64'(bus.issue_ready_o), 64'd0);
    fin();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.flush_i = 1'b0;  bus.issue_valid_i = 1'b0; bus.issue_chan_i = '0; bus.issue_tag_i = '0;
    bus.cmp_valid_i = '0; bus.cmp_id_i = '0; bus.cmp_result_i = '0; bus.cmp_status_i = '0;
    bus.cmp_ext_i = '0;  bus.out_ready_i = 1'b0;

    // Reset
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rdy",  64'(bus.issue_ready_o), 64'd0);
    chk("rst_oval", 64'(bus.out_valid_o),   64'd0);
    fin();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_count", 64'(bus.count_o),      64'd0);
    chk("post_rst_busy",  64'(bus.busy_o),       64'd0);
    chk("post_rst_err",   64'(bus.err_o),        64'd0);
    chk("post_rst_id",    64'(bus.issue_id_o),   64'd0);
    chk("post_rst_res",   64'(bus.result_o),     64'd0);
    chk("post_rst_rdy",   64'(bus.issue_ready_o), 64'd1);
    fin();

    // Out-of-order completion, in-order retirement
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iss(i, i + 1, 1'b1);
      @(negedge clk);
      chk("t1_issue_id", 64'(bus.issue_id_o), 64'(i));
      fin();
    end
    cmp_ok(2, 2, 3);
    @(negedge clk);
    chk("t1_count3", 64'(bus.count_o), 64'd3);
    chk("t1_oval_a", 64'(bus.out_valid_o), 64'd0);
    fin();
    cmp_ok(0, 0, 1);
    @(negedge clk); chk("t1_oval_b", 64'(bus.out_valid_o), 64'd0); fin();
    cmp_ok(1, 1, 2);
    @(negedge clk); chk("t1_oval_c", 64'(bus.out_valid_o), 64'd1); fin();
    @(negedge clk); chk("t1_oval_d", 64'(bus.out_valid_o), 64'd1); fin();
    cyc();
    @(negedge clk);
    chk("t1_oval_end", 64'(bus.out_valid_o), 64'd0);
    chk("t1_count0",   64'(bus.count_o), 64'd0);
    chk("t1_qempty",   64'(exp_q.size()), 64'd0);
    fin();

    // Fill, full, retire-vs-issue same cycle, wrap-around
    do_flush();
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      iss(i % 5, i + 4, 1'b1);
      @(negedge clk);
      chk("t2_issue_id", 64'(bus.issue_id_o), 64'(i));
      chk("t2_rdy",      64'(bus.issue_ready_o), 64'd1);
      fin();
    end
    @(negedge clk);
    chk("t2_full_rdy",   64'(bus.issue_ready_o), 64'd0);
    chk("t2_full_count", 64'(bus.count_o), 64'd8);
    chk("t2_full_busy",  64'(bus.busy_o), 64'd1);
    fin();
    cmp_ok(0, 0, 4);
    cyc();
    bus.out_ready_i = 1'b1;
    iss(0, 12, 1'b0);
    @(negedge clk);
    chk("t2_head_oval", 64'(bus.out_valid_o), 64'd1);
    chk("t2_rdy_retire", 64'(bus.issue_ready_o), 64'd0);
    fin();
    bus.out_ready_i = 1'b0;
    iss(0, 12, 1'b1);
    @(negedge clk);
    chk("t2_count7",  64'(bus.count_o), 64'd7);
    chk("t2_rdy_back", 64'(bus.issue_ready_o), 64'd1);
    chk("t2_wrap_id", 64'(bus.issue_id_o), 64'd0);
    fin();
    @(negedge clk);
    chk("t2_count8", 64'(bus.count_o), 64'd8);
    chk("t2_rdy8",   64'(bus.issue_ready_o), 64'd0);
    fin();
    bus.out_ready_i = 1'b1;
    for (int id = 7; id >= 2; id--) begin
      cmp_ok(id % 5, id, id + 4);
      cyc();
    end
    cmp_ok(1, 1, 5);
    cmp_ok(0, 0, 12);
    cyc();
    repeat (8) cyc();
    @(negedge clk);
    chk("t2_drain_count", 64'(bus.count_o), 64'd0);
    chk("t2_drain_busy",  64'(bus.busy_o), 64'd0);
    chk("t2_qempty",      64'(exp_q.size()), 64'd0);
    fin();

    // Same-cycle issue and completion of ID3
    iss(0, 13, 1'b1); cyc();
    iss(2, 14, 1'b1); cyc();
    iss(1, 15, 1'b1);
    cmp_ok(1, 3, 15);
    @(negedge clk); chk("t3_issue_id", 64'(bus.issue_id_o), 64'd3); fin();
    cmp_ok(0, 1, 13);
    cmp_ok(2, 2, 14);
    cyc();
    repeat (3) cyc();
    @(negedge clk);
    chk("t3_count0", 64'(bus.count_o), 64'd0);
    chk("t3_err",    64'(bus.err_o), 64'd0);
    chk("t3_qempty", 64'(exp_q.size()), 64'd0);
    fin();

    // Protocol errors
    do_flush();
    bus.out_ready_i = 1'b0;
    iss(0, 2, 1'b1); cyc();
    iss(0, 3, 1'b1); cyc();
    cmp(3, 5, 32'h1111_1111, 5'h01, 1'b1);
    @(negedge clk); chk("t4_err_pre", 64'(bus.err_o), 64'd0); fin();
    cmp_ok(0, 1, 3);
    cmp(2, 1, 32'hDEAD_BEEF, 5'h1F, 1'b1);
    @(negedge clk); chk("t4_err_free", 64'(bus.err_o), 64'd1); fin();
    cmp(1, 0, 32'hBAD0_0000, 5'h00, 1'b0);
    @(negedge clk); chk("t4_err_dup", 64'(bus.err_o), 64'd1); fin();
    cmp_ok(0, 0, 2);
    @(negedge clk); chk("t4_err_chan", 64'(bus.err_o), 64'd1); fin();
    bus.out_ready_i = 1'b1;
    @(negedge clk); chk("t4_oval", 64'(bus.out_valid_o), 64'd1); fin();
    cyc();
    @(negedge clk);
    chk("t4_err_sticky", 64'(bus.err_o), 64'd1);
    chk("t4_count0",     64'(bus.count_o), 64'd0);
    chk("t4_qempty",     64'(exp_q.size()), 64'd0);
    fin();
    do_flush();
    @(negedge clk); chk("t4_err_flushed", 64'(bus.err_o), 64'd0); fin();

    // Flush with work in flight, stale completion, reset mid-stream
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      iss(i, i + 4, 1'b1);
      cyc();
    end
    cmp_ok(0, 0, 4);
    cyc();
    @(negedge clk); chk("t5_head_oval", 64'(bus.out_valid_o), 64'd1); fin();
    bus.out_ready_i = 1'b1;
    bus.flush_i = 1'b1;
    @(negedge clk);
    chk("t5_flush_oval", 64'(bus.out_valid_o), 64'd0);
    chk("t5_flush_res",  64'(bus.result_o), 64'd0);
    fin();
    exp_q.delete();
    @(negedge clk);
    chk("t5_count0", 64'(bus.count_o), 64'd0);
    chk("t5_busy0",  64'(bus.busy_o), 64'd0);
    chk("t5_id0",    64'(bus.issue_id_o), 64'd0);
    fin();
    cmp(1, 1, 32'h5555_5555, 5'h02, 1'b0);
    cyc();
    @(negedge clk); chk("t5_stale_err", 64'(bus.err_o), 64'd1); fin();
    bus.out_ready_i = 1'b0;
    iss(0, 1, 1'b1); cyc();
    iss(1, 2, 1'b1);
    cmp_ok(0, 0, 1);
    cyc();
    @(negedge clk);
    chk("t5_pre_rst_oval",  64'(bus.out_valid_o), 64'd1);
    chk("t5_pre_rst_count", 64'(bus.count_o), 64'd2);
    fin();
    rst = 1'b1;
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    chk("t5_rst_oval", 64'(bus.out_valid_o), 64'd0);
    chk("t5_rst_rdy",  64'(bus.issue_ready_o), 64'd0);
    fin();
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("t5_rst_count", 64'(bus.count_o), 64'd0);
    chk("t5_rst_busy",  64'(bus.busy_o), 64'd0);
    chk("t5_rst_id",    64'(bus.issue_id_o), 64'd0);
    chk("t5_rst_err",   64'(bus.err_o), 64'd0);
    chk("t5_rst_oval2", 64'(bus.out_valid_o), 64'd0);
    fin();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
